// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline-side and data-bus signals
// of the memory-stage load/store unit.
`timescale 1ns/1ps
interface mem_access_unit_if;
  logic [31:0] ADDR_MEM;
  logic [31:0] MEMINPUTDATA_MEM;
  logic        MEMREAD_MEM;
  logic        MEMWRITE_MEM;
  logic [2:0]  FUNCT3_MEM;
  logic        DREQ;
  logic        DWE;
  logic [31:0] DADDR;
  logic [31:0] DWDATA;
  logic [3:0]  DBE;
  logic [31:0] DRDATA;
  logic        DACK;
  logic        STALL_MEM;
  logic [31:0] LOADDATA_WB;
  logic        LOADVALID_WB;
  logic        MISALIGN_WB;
  logic        BUSERR_WB;

  modport master (
    input  ADDR_MEM, MEMINPUTDATA_MEM,
    input  MEMREAD_MEM, MEMWRITE_MEM,
    input  FUNCT3_MEM, DRDATA, DACK,
    output DREQ, DWE, DADDR, DWDATA, DBE,
    output STALL_MEM, LOADDATA_WB,
    output LOADVALID_WB, MISALIGN_WB,
    output BUSERR_WB
  );

  modport slave (
    output ADDR_MEM, MEMINPUTDATA_MEM,
    output MEMREAD_MEM, MEMWRITE_MEM,
    output FUNCT3_MEM, DRDATA, DACK,
    input  DREQ, DWE, DADDR, DWDATA, DBE,
    input  STALL_MEM, LOADDATA_WB,
    input  LOADVALID_WB, MISALIGN_WB,
    input  BUSERR_WB
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with byte-lane
// formatting, req/ack bus cycle, timeout and load extension.
`timescale 1ns/1ps
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input logic CLK,
  input logic RESET,
  mem_access_unit_if.master bus
);
  localparam int CW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CW-1:0] TMAX = CW'(ACK_TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    alo_q;
  logic [2:0]    f3_q;

  logic        access;
  logic        legal;
  logic        done;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic [31:0] ldata;

  assign access = bus.MEMREAD_MEM | bus.MEMWRITE_MEM;

  // a BUSY cycle ends on ack or on the last allowed wait cycle
  assign done = bus.DACK | (cnt == TMAX);

  // stall while a legal access is issuing or waiting on the bus
  assign bus.STALL_MEM = (state == IDLE) ?
                         (access & legal) : ~done;

  // size/alignment legality of the access in MEM
  always_comb begin
    legal = 1'b0;
    unique case (bus.FUNCT3_MEM)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~bus.ADDR_MEM[0];
      3'b010:         legal = (bus.ADDR_MEM[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
  end

  // store data replication and byte-enable pattern
  always_comb begin
    wdata = bus.MEMINPUTDATA_MEM;
    be    = 4'b1111;
    unique case (1'b1)
      (bus.FUNCT3_MEM[1:0] == 2'b00): begin
        wdata = {4{bus.MEMINPUTDATA_MEM[7:0]}};
        be    = 4'b0001 << bus.ADDR_MEM[1:0];
      end
      (bus.FUNCT3_MEM[1:0] == 2'b01): begin
        wdata = {2{bus.MEMINPUTDATA_MEM[15:0]}};
        be    = bus.ADDR_MEM[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = bus.MEMINPUTDATA_MEM;
        be    = 4'b1111;
      end
    endcase
  end

  // lane select and extension using the latched offset/size
  always_comb begin
    lbyte = bus.DRDATA[{alo_q, 3'b000} +: 8];
    lhalf = alo_q[1] ? bus.DRDATA[31:16] : bus.DRDATA[15:0];
    ldata = bus.DRDATA;
    unique case (f3_q)
      3'b000:  ldata = {{24{lbyte[7]}}, lbyte};
      3'b100:  ldata = {24'h0, lbyte};
      3'b001:  ldata = {{16{lhalf[15]}}, lhalf};
      3'b101:  ldata = {16'h0, lhalf};
      default: ldata = bus.DRDATA;
    endcase
  end

  // issue/wait FSM with registered bus and writeback outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state            <= IDLE;
      cnt              <= '0;
      alo_q            <= '0;
      f3_q             <= '0;
      bus.DREQ         <= 1'b0;
      bus.DWE          <= 1'b0;
      bus.DADDR        <= '0;
      bus.DWDATA       <= '0;
      bus.DBE          <= '0;
      bus.LOADDATA_WB  <= '0;
      bus.LOADVALID_WB <= 1'b0;
      bus.MISALIGN_WB  <= 1'b0;
      bus.BUSERR_WB    <= 1'b0;
    end else begin
      bus.LOADVALID_WB <= 1'b0;
      bus.MISALIGN_WB  <= 1'b0;
      bus.BUSERR_WB    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (access && legal) begin
            state      <= BUSY;
            cnt        <= '0;
            bus.DREQ   <= 1'b1;
            bus.DWE    <= bus.MEMWRITE_MEM;
            bus.DADDR  <= {bus.ADDR_MEM[31:2], 2'b00};
            bus.DWDATA <= wdata;
            bus.DBE    <= be;
            alo_q      <= bus.ADDR_MEM[1:0];
            f3_q       <= bus.FUNCT3_MEM;
          end else if (access) begin
            bus.MISALIGN_WB <= 1'b1;
          end
        end
        BUSY: begin
          if (bus.DACK) begin
            state    <= IDLE;
            bus.DREQ <= 1'b0;
            if (!bus.DWE) begin
              bus.LOADDATA_WB  <= ldata;
              bus.LOADVALID_WB <= 1'b1;
            end
          end else if (cnt == TMAX) begin
            state         <= IDLE;
            bus.DREQ      <= 1'b0;
            bus.BUSERR_WB <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
